timer_digit_entry: RTL and testbench
====================================

TIMER_DIGIT_ENTRY -- requirements
Module: timer_digit_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable samples required to accept a key (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port D  input  4  key code from the keypad priority encoder; 0..9 are digits, 4'hF means no key.
REQ-005 SHALL have port validn  input  1  active-low key-present flag from the encoder; 1 means no key or disabled.
REQ-006 SHALL have port enablen  input  1  active-low entry enable; 1 means ignore keys.
REQ-007 SHALL have port clear  input  1  synchronous clear of the entered time.
REQ-008 SHALL have port digits  output  16  entered time as BCD {min_tens, min_ones, sec_tens, sec_ones}.
REQ-009 SHALL have port digit_count  output  3  number of digits entered, 0..4.
REQ-010 SHALL have port new_digit  output  1  one-cycle pulse when a digit is accepted.
REQ-011 SHALL have port full  output  1  high when digit_count equals 4.
REQ-012 SHALL have port key_held  output  1  high while an accepted key has not yet been released.

Function
REQ-013 SHALL implement an FSM with states IDLE, DEBOUNCE, HELD and RELEASE.
REQ-014 SHALL define a qualifying sample as validn=0, enablen=0 and D<=9; D in 10..14 SHALL be treated as no key.
REQ-015 IDLE: on a qualifying sample, SHALL capture D into key_reg, set cnt=1 and go to DEBOUNCE; if DEBOUNCE_CYCLES=1, SHALL accept immediately instead.
REQ-016 DEBOUNCE: a qualifying sample with D==key_reg SHALL increment cnt.
REQ-017 DEBOUNCE: a non-qualifying sample or a changed D SHALL return to IDLE with cnt=0 and no acceptance.
REQ-018 Acceptance SHALL occur on the edge at which cnt would reach DEBOUNCE_CYCLES; new_digit SHALL be 1 for exactly the following cycle and the FSM SHALL go to HELD.
REQ-019 On acceptance with digit_count<4, digits SHALL shift left by 4 bits, key_reg SHALL enter sec_ones, and digit_count SHALL increment.
REQ-020 On acceptance with digit_count=4, digits and digit_count SHALL be unchanged, new_digit SHALL still pulse, and the FSM SHALL go to HELD.
REQ-021 HELD: key_held=1; a non-qualifying sample SHALL go to RELEASE with cnt=1; a different qualifying key SHALL NOT be accepted.
REQ-022 RELEASE: DEBOUNCE_CYCLES consecutive non-qualifying samples SHALL return the FSM to IDLE; any qualifying sample SHALL return it to HELD.
REQ-023 cnt SHALL saturate and never wrap.
REQ-024 clear=1 SHALL zero digits and digit_count on the next edge.
REQ-025 If clear=1 coincides with acceptance, clear SHALL win: the digit is discarded, new_digit=0, and the FSM goes to HELD so the held key is not re-accepted.
REQ-026 enablen=1 in any state SHALL force IDLE on the next edge, cancelling any debounce in progress; digits SHALL be retained.
REQ-027 digits SHALL NOT be range-checked: sec_tens above 5 is stored as entered, and validation belongs to the downstream block.
REQ-028 full SHALL be combinational from digit_count==4; all other outputs SHALL be registered.

Reset
REQ-029 reset SHALL take priority over clear, enablen and keys.
REQ-030 On reset: state=IDLE, cnt=0, key_reg=4'hF, digits=16'h0000, digit_count=0, new_digit=0, key_held=0, full=0.
REQ-031 reset asserted mid-debounce or while HELD SHALL abort with no acceptance; a key still held after reset SHALL be debounced afresh from IDLE.

Structure
REQ-032 Package timer_pkg SHALL hold the state enumeration, NUM_DIGITS=4, BCD_W=4 and the KEY_NONE=4'hF constant, shared with the encoder and the countdown stages.
REQ-033 The stable-sample counter SHALL be one sub-module, key_debouncer, with inputs clk, reset, sample_ok and restart, and outputs stable (cnt reached DEBOUNCE_CYCLES); the FSM and digit register SHALL stay in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Hold D=5, validn=0 for 6 cycles -> exactly one new_digit pulse on the cycle after the 4th sample, digits=16'h0005, digit_count=1, key_held=1.
REQ-035 Press 1,2,3,0 with releases of 5 cycles or more between them -> digits=16'h1230, full=1; a fifth press of 7 -> new_digit pulses, digits stay 16'h1230.
REQ-036 Bounce: validn=0 for 3 cycles, 1 for 1 cycle, 0 for 3 cycles -> no new_digit and digits unchanged.
REQ-037 Hold 4 accepted, then validn bounces 1,0,1 before a steady 1 for 4 cycles -> only one acceptance; IDLE is reached after the 4 stable release cycles.
REQ-038 clear asserted on the acceptance edge of 9, with digits=16'h0012 -> digits=0, digit_count=0, new_digit=0; 9 is not accepted until it is released and pressed again.
REQ-039 reset pulsed during DEBOUNCE of 6, and enablen=1 mid-debounce -> all outputs at their reset values, no acceptance; after release, normal entry resumes.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer keypad chain: digit geometry, the
// "no key" code, the entry FSM state type and the key qualification rule.
package timer_pkg;

  localparam int          NUM_DIGITS    = 4;
  localparam int          BCD_W         = 4;
  localparam logic [3:0]  KEY_NONE      = 4'hF;
  localparam logic [3:0]  KEY_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } entry_state_e;

  // A sample counts as a key press only when the encoder flags a key, entry
  // is enabled and the code is a decimal digit; codes 10..15 are "no key".
  function automatic logic key_qualifies(input logic [3:0] code,
                                         input logic       validn,
                                         input logic       enablen);
    return (!validn) && (!enablen) && (code <= KEY_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Consecutive stable-sample counter. Counts edges on which sample_ok is high,
// drops to zero on any sample_ok=0 or restart, and saturates instead of
// wrapping. stable flags the sample that brings the run to DEBOUNCE_CYCLES.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_ok,
  input  logic restart,
  output logic stable
);

  localparam logic [7:0] CNT_MAX = 8'hFF;
  localparam logic [8:0] TARGET  = 9'(DEBOUNCE_CYCLES);

  logic [7:0] cnt_r;
  logic [7:0] cnt_next_s;

  // Next run length: restart or a broken run clears, otherwise count up to saturation
  always_comb begin
    cnt_next_s = 8'd0;
    if (restart) begin
      cnt_next_s = 8'd0;
    end else if (sample_ok) begin
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = CNT_MAX;
      end else begin
        cnt_next_s = cnt_r + 8'd1;
      end
    end else begin
      cnt_next_s = 8'd0;
    end
  end

  // Run-length register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign stable = sample_ok && (({1'b0, cnt_r} + 9'd1) >= TARGET);

endmodule

// File: rtl/timer_digit_entry.sv
// Keypad digit entry for the countdown timer. Debounces key presses and
// releases, shifts accepted digits into a 4-digit BCD register (mm:ss, stored
// unvalidated) and reports count, full and held status.
module timer_digit_entry
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D,
  input  logic        validn,
  input  logic        enablen,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        new_digit,
  output logic        full,
  output logic        key_held
);

  localparam int         DIG_W     = NUM_DIGITS * BCD_W;
  localparam logic [2:0] COUNT_MAX = 3'(NUM_DIGITS);

  entry_state_e     state_r;
  entry_state_e     state_next_s;
  logic [3:0]       key_reg_r;
  logic [3:0]       key_reg_next_s;
  logic [DIG_W-1:0] digits_r;
  logic [DIG_W-1:0] digits_next_s;
  logic [2:0]       count_r;
  logic [2:0]       count_next_s;
  logic             new_digit_r;
  logic             new_digit_s;
  logic             key_held_r;
  logic             key_held_s;

  logic sample_q_s;
  logic press_phase_s;
  logic sample_ok_s;
  logic stable_s;
  logic accept_s;
  logic release_done_s;
  logic restart_s;

  assign sample_q_s    = key_qualifies(D, validn, enablen);
  assign press_phase_s = (state_r == IDLE) || (state_r == DEBOUNCE);

  // While waiting for a press the counter tracks a steady qualifying key;
  // while a key is down it tracks consecutive non-qualifying samples.
  assign sample_ok_s    = press_phase_s
                          ? (sample_q_s && ((state_r == IDLE) || (D == key_reg_r)))
                          : !sample_q_s;
  assign accept_s       = press_phase_s && stable_s;
  assign release_done_s = (state_r == RELEASE) && stable_s;
  // Every jump between the press and release phases starts a fresh run
  assign restart_s      = enablen || accept_s || release_done_s;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .sample_ok (sample_ok_s),
    .restart   (restart_s),
    .stable    (stable_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; disabling entry always drops back to IDLE
  always_comb begin
    state_next_s = state_r;
    if (enablen) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_next_s = HELD;
          end else if (sample_q_s) begin
            state_next_s = DEBOUNCE;
          end else begin
            state_next_s = IDLE;
          end
        end
        DEBOUNCE: begin
          if (accept_s) begin
            state_next_s = HELD;
          end else if (sample_ok_s) begin
            state_next_s = DEBOUNCE;
          end else begin
            state_next_s = IDLE;
          end
        end
        HELD: begin
          if (!sample_q_s) begin
            state_next_s = RELEASE;
          end else begin
            state_next_s = HELD;
          end
        end
        RELEASE: begin
          if (release_done_s) begin
            state_next_s = IDLE;
          end else if (sample_q_s) begin
            state_next_s = HELD;
          end else begin
            state_next_s = RELEASE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Output and datapath next values; clear beats a coincident acceptance
  always_comb begin
    new_digit_s    = accept_s && !clear;
    key_held_s     = (state_next_s == HELD) || (state_next_s == RELEASE);
    digits_next_s  = digits_r;
    count_next_s   = count_r;
    key_reg_next_s = key_reg_r;
    if ((state_r == IDLE) && sample_q_s) begin
      key_reg_next_s = D;
    end else begin
      key_reg_next_s = key_reg_r;
    end
    if (clear) begin
      digits_next_s = {DIG_W{1'b0}};
      count_next_s  = 3'd0;
    end else if (accept_s && (count_r < COUNT_MAX)) begin
      digits_next_s = {digits_r[DIG_W-BCD_W-1:0], D};
      count_next_s  = count_r + 3'd1;
    end else begin
      digits_next_s = digits_r;
      count_next_s  = count_r;
    end
  end

  // Registered outputs and digit storage
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg_r   <= KEY_NONE;
      digits_r    <= {DIG_W{1'b0}};
      count_r     <= 3'd0;
      new_digit_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_reg_r   <= key_reg_next_s;
      digits_r    <= digits_next_s;
      count_r     <= count_next_s;
      new_digit_r <= new_digit_s;
      key_held_r  <= key_held_s;
    end
  end

  assign digits      = digits_r;
  assign digit_count = count_r;
  assign new_digit   = new_digit_r;
  assign key_held    = key_held_r;
  assign full        = (count_r == COUNT_MAX);

endmodule

// File: tb/tb_timer_digit_entry.sv
// Directed bench for timer_digit_entry with DEBOUNCE_CYCLES=4. A behavioural
// model (run lengths plus a queue of entered digits) predicts every output on
// every cycle; literal checks pin the key scenarios.
module tb_timer_digit_entry;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  D = 4'hF;
  logic        validn = 1'b1;
  logic        enablen = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        new_digit;
  logic        full;
  logic        key_held;

  always #5 clk = ~clk;

  timer_digit_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .D           (D),
    .validn      (validn),
    .enablen     (enablen),
    .clear       (clear),
    .digits      (digits),
    .digit_count (digit_count),
    .new_digit   (new_digit),
    .full        (full),
    .key_held    (key_held)
  );

  int vectors = 0;
  int miscompares = 0;

  // behavioural model
  int  press_run = 0;
  int  press_key = 15;
  int  rel_run = 0;
  bit  locked = 1'b0;
  bit  m_new = 1'b0;
  int  digs[$];

  int pulses = 0;
  int step_no = 0;
  int last_pulse_step = -1;

  function automatic logic [15:0] model_digits();
    logic [15:0] r;
    r = 16'h0000;
    foreach (digs[i]) r = (r << 4) | 16'(digs[i]);
    return r;
  endfunction

  task automatic model_edge();
    bit q;
    bit acc;
    q   = (!validn) && (!enablen) && (int'(D) <= 9);
    acc = 1'b0;
    if (reset) begin
      press_run = 0; rel_run = 0; locked = 1'b0; m_new = 1'b0;
      digs.delete();
    end else begin
      if (enablen) begin
        locked = 1'b0; press_run = 0; rel_run = 0;
      end else if (!locked) begin
        if (q && (press_run == 0 || int'(D) == press_key)) begin
          press_run++;
          press_key = int'(D);
        end else begin
          press_run = 0;
        end
        if (press_run == N) begin
          acc = 1'b1; locked = 1'b1; press_run = 0; rel_run = 0;
        end
      end else begin
        if (q) rel_run = 0;
        else rel_run++;
        if (rel_run == N) begin
          locked = 1'b0; rel_run = 0;
        end
      end
      m_new = acc && !clear;
      if (clear) digs.delete();
      else if (acc && digs.size() < 4) digs.push_back(int'(D));
    end
  endtask

  task automatic compare();
    logic [15:0] ed;
    logic [2:0]  ec;
    logic        ef;
    ed = model_digits();
    ec = 3'(digs.size());
    ef = (digs.size() == 4);
    vectors++;
    if (digits !== ed || digit_count !== ec || new_digit !== m_new ||
        key_held !== locked || full !== ef) begin
      miscompares++;
      $display("FAIL step%0d outputs: got digits=%h cnt=%0d new=%b held=%b full=%b, expected digits=%h cnt=%0d new=%b held=%b full=%b",
               step_no, digits, digit_count, new_digit, key_held, full,
               ed, ec, m_new, locked, ef);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic en,
                      input logic vn, input logic [3:0] d);
    reset = r; clear = c; enablen = en; validn = vn; D = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    step_no++;
    compare();
    if (new_digit === 1'b1) begin
      pulses++;
      last_pulse_step = step_no;
    end
  endtask

  task automatic press(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic release_key(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
  endtask

  initial begin
    int p0;
    int s0;

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
    check_lit("reset_digits", int'(digits), 0);
    check_lit("reset_held", int'(key_held), 0);

    // single key held 6 cycles
    p0 = pulses; s0 = step_no;
    press(4'd5, 6);
    check_lit("hold5_pulses", pulses - p0, 1);
    check_lit("hold5_pulse_cycle", last_pulse_step - s0, 4);
    check_lit("hold5_digits", int'(digits), 16'h0005);
    check_lit("hold5_count", int'(digit_count), 1);
    check_lit("hold5_held", int'(key_held), 1);
    release_key(5);
    check_lit("rel5_held", int'(key_held), 0);

    // four digits then a fifth press on a full register
    do_clear();
    press(4'd1, 5); release_key(5);
    press(4'd2, 5); release_key(5);
    press(4'd3, 5); release_key(5);
    press(4'd0, 5); release_key(5);
    check_lit("four_digits", int'(digits), 16'h1230);
    check_lit("four_full", int'(full), 1);
    p0 = pulses;
    press(4'd7, 5);
    check_lit("fifth_pulse", pulses - p0, 1);
    check_lit("fifth_digits", int'(digits), 16'h1230);
    check_lit("fifth_count", int'(digit_count), 4);
    release_key(5);

    // bounce during debounce
    do_clear();
    p0 = pulses;
    press(4'd8, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    press(4'd8, 3);
    release_key(5);
    check_lit("bounce_pulses", pulses - p0, 0);
    check_lit("bounce_digits", int'(digits), 0);

    // held key, different key while held, then bouncy release
    p0 = pulses;
    press(4'd4, 5);
    press(4'd2, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    check_lit("bounce_rel_held", int'(key_held), 1);
    release_key(4);
    check_lit("relbounce_pulses", pulses - p0, 1);
    check_lit("relbounce_digits", int'(digits), 16'h0004);
    check_lit("relbounce_idle", int'(key_held), 0);

    // clear on the acceptance edge
    do_clear();
    press(4'd1, 5); release_key(5);
    press(4'd2, 5); release_key(5);
    check_lit("pre_clear_digits", int'(digits), 16'h0012);
    p0 = pulses;
    press(4'd9, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
    check_lit("clracc_new", int'(new_digit), 0);
    check_lit("clracc_digits", int'(digits), 0);
    check_lit("clracc_count", int'(digit_count), 0);
    press(4'd9, 4);
    check_lit("clracc_no_reaccept", pulses - p0, 0);
    release_key(5);
    press(4'd9, 5);
    check_lit("repress9_digits", int'(digits), 16'h0009);
    release_key(5);

    // reset mid-debounce, then enable dropped mid-debounce
    p0 = pulses;
    press(4'd6, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
    check_lit("rst_digits", int'(digits), 0);
    check_lit("rst_count", int'(digit_count), 0);
    check_lit("rst_new", int'(new_digit), 0);
    check_lit("rst_full", int'(full), 0);
    press(4'd6, 3);
    release_key(5);
    press(4'd6, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
    press(4'd6, 2);
    release_key(5);
    check_lit("abort_pulses", pulses - p0, 0);
    press(4'd3, 5);
    release_key(5);
    check_lit("resume_digits", int'(digits), 16'h0003);
    check_lit("resume_count", int'(digit_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
